// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock controller: mode encodings,
// time-of-day limits, button indices and the commit clamp helpers.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    CLOCK   = 2'b00,
    ADJUST  = 2'b01,
    RINGING = 2'b10,
    SNOOZE  = 2'b11
  } state_e;

  localparam logic [4:0] MAX_HOURS   = 5'd23;
  localparam logic [5:0] MAX_MINUTES = 6'd59;
  localparam logic [5:0] MAX_SECONDS = 6'd59;

  localparam int BTN_CENTER = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 4;

  // Out-of-range hours from the adjust datapath saturate at 23.
  function automatic logic [4:0] clamp_hours(input logic [4:0] h);
    if (h > MAX_HOURS) begin
      return MAX_HOURS;
    end else begin
      return h;
    end
  endfunction

  // Out-of-range minutes from the adjust datapath saturate at 59.
  function automatic logic [5:0] clamp_minutes(input logic [5:0] m);
    if (m > MAX_MINUTES) begin
      return MAX_MINUTES;
    end else begin
      return m;
    end
  endfunction

endpackage

// File: rtl/alarm_clock_controller_time_of_day_counter.sv
// hh:mm:ss time-of-day counter. Advances on tick while enabled, wraps
// 23:59:59 -> 00:00:00, and supports a synchronous load of hh:mm that
// clears the seconds. The post-tick value is exported so the owner can
// detect a match on the exact tick that produces it.
module time_of_day_counter
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] next_hours,
  output logic [5:0] next_minutes,
  output logic [5:0] next_seconds
);

  logic [4:0] hours_q,   hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;

  // Value the counter takes after one tick, including the rollover chain.
  always_comb begin
    next_seconds = seconds_q;
    next_minutes = minutes_q;
    next_hours   = hours_q;
    if (seconds_q >= MAX_SECONDS) begin
      next_seconds = 6'd0;
      if (minutes_q >= MAX_MINUTES) begin
        next_minutes = 6'd0;
        if (hours_q >= MAX_HOURS) begin
          next_hours = 5'd0;
        end else begin
          next_hours = hours_q + 5'd1;
        end
      end else begin
        next_minutes = minutes_q + 6'd1;
      end
    end else begin
      next_seconds = seconds_q + 6'd1;
    end
  end

  // Load has priority over counting; ticks are dropped while disabled.
  always_comb begin
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    if (load) begin
      hours_d   = load_hours;
      minutes_d = load_minutes;
      seconds_d = 6'd0;
    end else if (en && tick) begin
      hours_d   = next_hours;
      minutes_d = next_minutes;
      seconds_d = next_seconds;
    end else begin
      hours_d   = hours_q;
      minutes_d = minutes_q;
      seconds_d = seconds_q;
    end
  end

  // Time-of-day registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours_q   <= 5'd0;
      minutes_q <= 6'd0;
      seconds_q <= 6'd0;
    end else begin
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;

endmodule

// File: rtl/alarm_clock_controller.sv
// Alarm clock mode controller: keeps time of day and the alarm, drives the
// adjust datapath (enable / preload / commit) and the buzzer.
// Optional macro SNOOZE_EN adds the SNOOZE state (up button while ringing).
module alarm_clock_controller
  import alarm_clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [4:0] button_out,
  input  logic [1:0] adjusted,
  input  logic [4:0] adj_time_hours,
  input  logic [5:0] adj_time_minutes,
  input  logic [4:0] adj_alarm_hours,
  input  logic [5:0] adj_alarm_minutes,
  output logic       adj_enable,
  output logic       adj_load,
  output logic [4:0] time_hours,
  output logic [5:0] time_minutes,
  output logic [5:0] time_seconds,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm_armed,
  output logic       buzzer,
  output logic [1:0] mode_led
);

  if (RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_bad_ring_seconds
    $error("RING_SECONDS must be in 1..255");
  end
  if (SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 59) begin : g_bad_snooze_minutes
    $error("SNOOZE_MINUTES must be in 1..59");
  end

  localparam logic [8:0] RING_LIMIT = 9'(RING_SECONDS);

  // Buttons that end ringing; with snooze the up button is taken out.
`ifdef SNOOZE_EN
  localparam logic [4:0] DISMISS_MASK = (5'd1 << BTN_CENTER) | (5'd1 << BTN_LEFT) |
                                        (5'd1 << BTN_RIGHT)  | (5'd1 << BTN_DOWN);
  localparam logic [11:0] SNOOZE_TICKS = 12'(SNOOZE_MINUTES * 60);
  logic [11:0] snooze_cnt_q, snooze_cnt_d;
  logic [11:0] snooze_next_s;
`else
  localparam logic [4:0] DISMISS_MASK = (5'd1 << BTN_CENTER) | (5'd1 << BTN_LEFT) |
                                        (5'd1 << BTN_RIGHT)  | (5'd1 << BTN_UP) |
                                        (5'd1 << BTN_DOWN);
`endif

  state_e     state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [8:0] ring_next_s;
  logic [4:0] alarm_hours_q, alarm_hours_d;
  logic [5:0] alarm_minutes_q, alarm_minutes_d;
  logic       alarm_armed_q, alarm_armed_d;
  logic       adj_enable_q, adj_enable_d;
  logic       adj_load_q, adj_load_d;
  logic       buzzer_q, buzzer_d;
  logic [1:0] mode_led_q, mode_led_d;

  logic       tod_en_s, tod_load_s, match_s;
  logic [4:0] tod_hours_s, tod_next_hours_s;
  logic [5:0] tod_minutes_s, tod_next_minutes_s;
  logic [5:0] tod_seconds_s, tod_next_seconds_s;

  // Time freezes while the user is adjusting.
  assign tod_en_s = (state_q != ADJUST);

  time_of_day_counter u_tod (
    .clk          (clk),
    .rst_n        (reset),
    .en           (tod_en_s),
    .tick         (tick_1hz),
    .load         (tod_load_s),
    .load_hours   (clamp_hours(adj_time_hours)),
    .load_minutes (clamp_minutes(adj_time_minutes)),
    .hours        (tod_hours_s),
    .minutes      (tod_minutes_s),
    .seconds      (tod_seconds_s),
    .next_hours   (tod_next_hours_s),
    .next_minutes (tod_next_minutes_s),
    .next_seconds (tod_next_seconds_s)
  );

  // Only a tick landing on hh:mm:00 can fire the alarm, never a load.
  assign match_s = tick_1hz && alarm_armed_q && (tod_next_seconds_s == 6'd0) &&
                   (tod_next_hours_s == alarm_hours_q) &&
                   (tod_next_minutes_s == alarm_minutes_q);

  assign ring_next_s = {1'b0, ring_cnt_q} + 9'd1;

  // Next-state, commit and registered-output decode for the mode FSM.
  always_comb begin
    state_d         = state_q;
    ring_cnt_d      = ring_cnt_q;
    alarm_hours_d   = alarm_hours_q;
    alarm_minutes_d = alarm_minutes_q;
    alarm_armed_d   = alarm_armed_q;
    tod_load_s      = 1'b0;
`ifdef SNOOZE_EN
    snooze_cnt_d    = snooze_cnt_q;
    snooze_next_s   = snooze_cnt_q + 12'd1;
`endif
    case (state_q)
      CLOCK: begin
        if (match_s) begin
          state_d    = RINGING;
          ring_cnt_d = 8'd0;
        end else if (button_out[BTN_CENTER]) begin
          state_d = ADJUST;
        end else begin
          state_d = CLOCK;
        end
      end
      ADJUST: begin
        if (button_out[BTN_CENTER]) begin
          state_d    = CLOCK;
          tod_load_s = adjusted[0];
          if (adjusted[1]) begin
            alarm_hours_d   = clamp_hours(adj_alarm_hours);
            alarm_minutes_d = clamp_minutes(adj_alarm_minutes);
            alarm_armed_d   = 1'b1;
          end else begin
            alarm_armed_d   = alarm_armed_q;
          end
        end else begin
          state_d = ADJUST;
        end
      end
      RINGING: begin
        if (tick_1hz) begin
          ring_cnt_d = ring_next_s[7:0];
        end else begin
          ring_cnt_d = ring_cnt_q;
        end
        if (|(button_out & DISMISS_MASK)) begin
          state_d = CLOCK;
`ifdef SNOOZE_EN
        end else if (button_out[BTN_UP]) begin
          state_d      = SNOOZE;
          snooze_cnt_d = 12'd0;
`endif
        end else if (tick_1hz && (ring_next_s >= RING_LIMIT)) begin
          state_d = CLOCK;
        end else begin
          state_d = RINGING;
        end
      end
      SNOOZE: begin
`ifdef SNOOZE_EN
        if (button_out[BTN_CENTER]) begin
          state_d = CLOCK;
        end else if (tick_1hz) begin
          if (snooze_next_s >= SNOOZE_TICKS) begin
            state_d      = RINGING;
            ring_cnt_d   = 8'd0;
            snooze_cnt_d = 12'd0;
          end else begin
            state_d      = SNOOZE;
            snooze_cnt_d = snooze_next_s;
          end
        end else begin
          state_d = SNOOZE;
        end
`else
        state_d = CLOCK;
`endif
      end
      default: begin
        state_d = CLOCK;
      end
    endcase

    adj_enable_d = (state_d == ADJUST);
    adj_load_d   = (state_q == CLOCK) && (state_d == ADJUST);
    buzzer_d     = (state_d == RINGING);
    mode_led_d   = state_d;
  end

  // Mode state, alarm storage, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= CLOCK;
      ring_cnt_q      <= 8'd0;
      alarm_hours_q   <= 5'd0;
      alarm_minutes_q <= 6'd0;
      alarm_armed_q   <= 1'b0;
      adj_enable_q    <= 1'b0;
      adj_load_q      <= 1'b0;
      buzzer_q        <= 1'b0;
      mode_led_q      <= 2'b00;
    end else begin
      state_q         <= state_d;
      ring_cnt_q      <= ring_cnt_d;
      alarm_hours_q   <= alarm_hours_d;
      alarm_minutes_q <= alarm_minutes_d;
      alarm_armed_q   <= alarm_armed_d;
      adj_enable_q    <= adj_enable_d;
      adj_load_q      <= adj_load_d;
      buzzer_q        <= buzzer_d;
      mode_led_q      <= mode_led_d;
    end
  end

`ifdef SNOOZE_EN
  // Snooze tick counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snooze_cnt_q <= 12'd0;
    end else begin
      snooze_cnt_q <= snooze_cnt_d;
    end
  end
`endif

  assign adj_enable    = adj_enable_q;
  assign adj_load      = adj_load_q;
  assign time_hours    = tod_hours_s;
  assign time_minutes  = tod_minutes_s;
  assign time_seconds  = tod_seconds_s;
  assign alarm_hours   = alarm_hours_q;
  assign alarm_minutes = alarm_minutes_q;
  assign alarm_armed   = alarm_armed_q;
  assign buzzer        = buzzer_q;
  assign mode_led      = mode_led_q;

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Table-driven self-checking bench for alarm_clock_controller. Each record
// holds the stimulus for a (repeated) cycle and the outputs expected after
// its last repetition; expectations go through a scoreboard queue.
// Build with or without SNOOZE_EN; expectations follow the macro.
module tb_alarm_clock_controller;

`ifdef SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic [4:0] button_out;
  logic [1:0] adjusted;
  logic [4:0] adj_time_hours;
  logic [5:0] adj_time_minutes;
  logic [4:0] adj_alarm_hours;
  logic [5:0] adj_alarm_minutes;
  logic       adj_enable;
  logic       adj_load;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [5:0] time_seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_armed;
  logic       buzzer;
  logic [1:0] mode_led;

  alarm_clock_controller #(.RING_SECONDS(60), .SNOOZE_MINUTES(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .tick_1hz          (tick_1hz),
    .button_out        (button_out),
    .adjusted          (adjusted),
    .adj_time_hours    (adj_time_hours),
    .adj_time_minutes  (adj_time_minutes),
    .adj_alarm_hours   (adj_alarm_hours),
    .adj_alarm_minutes (adj_alarm_minutes),
    .adj_enable        (adj_enable),
    .adj_load          (adj_load),
    .time_hours        (time_hours),
    .time_minutes      (time_minutes),
    .time_seconds      (time_seconds),
    .alarm_hours       (alarm_hours),
    .alarm_minutes     (alarm_minutes),
    .alarm_armed       (alarm_armed),
    .buzzer            (buzzer),
    .mode_led          (mode_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         reps;
    logic       tick;
    logic [4:0] btn;
    logic [1:0] adjd;
    logic [4:0] ith;
    logic [5:0] itm;
    logic [4:0] iah;
    logic [5:0] iam;
    logic [1:0] mode;
    logic       buz;
    logic       en;
    logic       ld;
    logic [4:0] th;
    logic [5:0] tm;
    logic [5:0] ts;
    logic [4:0] ah;
    logic [5:0] am;
    logic       armed;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb[$];
  vec_t tbl[36];

  function automatic vec_t V(int reps, int tick, int btn, int adjd, int ith, int itm,
                             int iah, int iam, int mode, int buz, int en, int ld,
                             int th, int tm, int ts, int ah, int am, int armed);
    vec_t v;
    v.reps = reps;   v.tick = 1'(tick); v.btn = 5'(btn);  v.adjd = 2'(adjd);
    v.ith = 5'(ith); v.itm = 6'(itm);   v.iah = 5'(iah);  v.iam = 6'(iam);
    v.mode = 2'(mode); v.buz = 1'(buz); v.en = 1'(en);    v.ld = 1'(ld);
    v.th = 5'(th);   v.tm = 6'(tm);     v.ts = 6'(ts);
    v.ah = 5'(ah);   v.am = 6'(am);     v.armed = 1'(armed);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare(string tag, vec_t e);
    chk({tag, ".mode_led"},    32'(mode_led),      32'(e.mode));
    chk({tag, ".buzzer"},      32'(buzzer),        32'(e.buz));
    chk({tag, ".adj_enable"},  32'(adj_enable),    32'(e.en));
    chk({tag, ".adj_load"},    32'(adj_load),      32'(e.ld));
    chk({tag, ".time_h"},      32'(time_hours),    32'(e.th));
    chk({tag, ".time_m"},      32'(time_minutes),  32'(e.tm));
    chk({tag, ".time_s"},      32'(time_seconds),  32'(e.ts));
    chk({tag, ".alarm_h"},     32'(alarm_hours),   32'(e.ah));
    chk({tag, ".alarm_m"},     32'(alarm_minutes), 32'(e.am));
    chk({tag, ".alarm_armed"}, 32'(alarm_armed),   32'(e.armed));
  endtask

  // Drive a record for reps cycles; expectation queued with the last drive
  // and popped once the DUT has clocked it.
  task automatic apply(string tag, vec_t v);
    vec_t e;
    for (int r = 0; r < v.reps; r++) begin
      @(negedge clk);
      tick_1hz          = v.tick;
      button_out        = v.btn;
      adjusted          = v.adjd;
      adj_time_hours    = v.ith;
      adj_time_minutes  = v.itm;
      adj_alarm_hours   = v.iah;
      adj_alarm_minutes = v.iam;
      if (r == v.reps - 1) sb.push_back(v);
      @(posedge clk);
      #1;
      tick_1hz   = 1'b0;
      button_out = 5'd0;
      adjusted   = 2'd0;
      if (r == v.reps - 1) begin
        e = sb.pop_front();
        compare(tag, e);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; tick_1hz = 1'b0; button_out = 5'd0; adjusted = 2'd0;
    adj_time_hours = 5'd0; adj_time_minutes = 6'd0;
    adj_alarm_hours = 5'd0; adj_alarm_minutes = 6'd0;

    //          reps  tk btn ad ith itm iah iam | mode bz en ld  th tm ts  ah am arm
    tbl[0]  = V(3661, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   1, 1, 1,   0, 0, 0);
    tbl[1]  = V(1,    0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 1,   1, 1, 1,   0, 0, 0);
    tbl[2]  = V(1,    0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0,   1, 1, 1,   0, 0, 0);
    tbl[3]  = V(10,   1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0,   1, 1, 1,   0, 0, 0);
    tbl[4]  = V(1,    1, 10, 0, 0, 0, 0, 0,  1, 0, 1, 0,   1, 1, 1,   0, 0, 0);
    tbl[5]  = V(1,    0, 1, 1, 7, 30, 12, 34, 0, 0, 0, 0,  7, 30, 0,  0, 0, 0);
    tbl[6]  = V(1,    1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 30, 1,  0, 0, 0);
    tbl[7]  = V(1,    1, 1, 0, 0, 0, 0, 0,   1, 0, 1, 1,   7, 30, 2,  0, 0, 0);
    tbl[8]  = V(1,    0, 1, 2, 0, 0, 7, 31,  0, 0, 0, 0,   7, 30, 2,  7, 31, 1);
    tbl[9]  = V(56,   1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 30, 58, 7, 31, 1);
    tbl[10] = V(1,    1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 30, 59, 7, 31, 1);
    tbl[11] = V(1,    1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0,   7, 31, 0,  7, 31, 1);
    tbl[12] = V(59,   1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0,   7, 31, 59, 7, 31, 1);
    tbl[13] = V(1,    1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 32, 0,  7, 31, 1);
    tbl[14] = V(1,    0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 1,   7, 32, 0,  7, 31, 1);
    tbl[15] = V(1,    0, 1, 2, 0, 0, 7, 33,  0, 0, 0, 0,   7, 32, 0,  7, 33, 1);
    tbl[16] = V(59,   1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 32, 59, 7, 33, 1);
    tbl[17] = V(1,    1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0,   7, 33, 0,  7, 33, 1);
    tbl[18] = V(4,    1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0,   7, 33, 4,  7, 33, 1);
    tbl[19] = V(1,    1, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 33, 5,  7, 33, 1);
    tbl[20] = V(1,    0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 1,   7, 33, 5,  7, 33, 1);
    tbl[21] = V(1,    0, 1, 2, 0, 0, 7, 34,  0, 0, 0, 0,   7, 33, 5,  7, 34, 1);
    tbl[22] = V(54,   1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 33, 59, 7, 34, 1);
    tbl[23] = V(1,    1, 1, 0, 0, 0, 0, 0,   2, 1, 0, 0,   7, 34, 0,  7, 34, 1);
    tbl[24] = V(1,    0, 8, 0, 0, 0, 0, 0,   SNZ ? 3 : 0, 0, 0, 0, 7, 34, 0, 7, 34, 1);
    tbl[25] = V(59,   1, 0, 0, 0, 0, 0, 0,   SNZ ? 3 : 0, 0, 0, 0, 7, 34, 59, 7, 34, 1);
    tbl[26] = V(1,    1, 0, 0, 0, 0, 0, 0,   SNZ ? 2 : 0, int'(SNZ), 0, 0, 7, 35, 0, 7, 34, 1);
    tbl[27] = V(1,    0, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0,   7, 35, 0,  7, 34, 1);
    tbl[28] = V(1,    0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 1,   7, 35, 0,  7, 34, 1);
    tbl[29] = V(1,    0, 1, 3, 31, 63, 30, 60, 0, 0, 0, 0, 23, 59, 0, 23, 59, 1);
    tbl[30] = V(59,   1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   23, 59, 59, 23, 59, 1);
    tbl[31] = V(1,    1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0,   23, 59, 1);
    tbl[32] = V(1,    0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 1,   0, 0, 0,   23, 59, 1);
    tbl[33] = V(1,    0, 1, 2, 0, 0, 0, 1,   0, 0, 0, 0,   0, 0, 0,   0, 1, 1);
    tbl[34] = V(60,   1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0,   0, 1, 0,   0, 1, 1);
    tbl[35] = V(1,    1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1,   0, 0, 0);

    // Reset state while reset is held.
    #3;
    compare("reset", V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 35; i++) begin
      apply($sformatf("v%0d", i), tbl[i]);
    end

    // Asynchronous reset between edges while ringing.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    compare("async_reset", V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    apply("post_reset", tbl[35]);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_clock_controller.md
Name: alarm_clock_controller

Overview:
- Top-level mode controller for the alarm clock.
- Owns the running time-of-day (hh:mm:ss) and the stored alarm time.
- Sequences the adjust datapath: enables it, preloads it, and commits its adjusted values.
- Detects the alarm match and drives the buzzer through the ringing and snooze states.

Parameters:
- RING_SECONDS, 60, seconds the buzzer rings before auto-dismiss (1..255).
- SNOOZE_MINUTES, 5, snooze length in minutes (1..59); used only with SNOOZE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse once per second
- button_out  in  5  debounced one-cycle pulses: [0] centre/mode, [1] left, [2] right, [3] up, [4] down
- adjusted  in  2  from the adjust datapath: [0] time changed, [1] alarm changed
- adj_time_hours  in  5  adjusted time hours (0..23)
- adj_time_minutes  in  6  adjusted time minutes (0..59)
- adj_alarm_hours  in  5  adjusted alarm hours (0..23)
- adj_alarm_minutes  in  6  adjusted alarm minutes (0..59)
- adj_enable  out  1  high while in ADJUST
- adj_load  out  1  one-cycle pulse on ADJUST entry; the datapath preloads from the time/alarm outputs
- time_hours  out  5  current hours
- time_minutes  out  6  current minutes
- time_seconds  out  6  current seconds
- alarm_hours  out  5  stored alarm hours
- alarm_minutes  out  6  stored alarm minutes
- alarm_armed  out  1  alarm active
- buzzer  out  1  high while RINGING
- mode_led  out  2  00 CLOCK, 01 ADJUST, 10 RINGING, 11 SNOOZE

Behaviour:
- Reset (reset=0, asynchronous):
  - state CLOCK; time 00:00:00; alarm 00:00.
  - alarm_armed=0; adj_enable=0, adj_load=0, buzzer=0, mode_led=00.
  - ring and snooze counters 0.
- All outputs are registered. A state change is visible the cycle after the triggering pulse.
- Time counting:
  - Advances on tick_1hz in CLOCK, RINGING and SNOOZE.
  - Frozen in ADJUST; ticks during ADJUST are discarded.
  - Rollover chain: seconds 59->0 carries into minutes; minutes 59->0 carries into hours; 23:59:59 wraps to 00:00:00.
- CLOCK:
  - button_out[0] -> ADJUST; adj_load pulses for exactly one cycle.
  - Other buttons are ignored.
- ADJUST:
  - button_out[0] -> CLOCK.
  - In the same edge, if adjusted[0]=1: time <= adj_time_*, seconds <= 0.
  - In the same edge, if adjusted[1]=1: alarm <= adj_alarm_* and alarm_armed <= 1.
  - If both bits are 0, nothing changes.
  - Buttons [1..4] belong to the datapath and are ignored here.
- Alarm match: in CLOCK, a tick that produces seconds==0 with hh:mm equal to the alarm and alarm_armed=1 -> RINGING.
  - A match entered by a load from ADJUST does not trigger; only a tick triggers.
- RINGING:
  - buzzer=1; the ring counter counts ticks.
  - Any button pulse dismisses -> CLOCK, with alarm_armed kept at 1.
  - Ring counter reaching RING_SECONDS -> CLOCK.
  - The ring counter clears on entry.
- Simultaneous events:
  - Tick and button in the same cycle: the time advances and the state transitions.
  - Dismiss and timeout in the same cycle: CLOCK.
  - Alarm-match tick and button_out[0] in the same cycle in CLOCK: RINGING wins; the button is dropped.
- Out-of-range adj_* inputs (hours >23, minutes >59) are clamped to 23/59 on commit.

Optional Feature:
- Macro: SNOOZE_EN.
- Defined:
  - In RINGING, button_out[3] -> SNOOZE (buzzer=0, mode_led=11); all other buttons dismiss as above.
  - SNOOZE counts SNOOZE_MINUTES*60 ticks, then returns to RINGING with the ring counter cleared.
  - button_out[0] in SNOOZE cancels -> CLOCK.
  - Snooze repeats indefinitely.
- Undefined: no SNOOZE state or counter exist; button_out[3] dismisses like any other button; mode_led never shows 11.

Decomposition:
- Package alarm_clock_pkg:
  - State encodings: CLOCK=2'b00, ADJUST=2'b01, RINGING=2'b10, SNOOZE=2'b11.
  - MAX_HOURS=23, MAX_MINUTES=59, MAX_SECONDS=59.
  - Button indices: BTN_CENTER=0, BTN_LEFT=1, BTN_RIGHT=2, BTN_UP=3, BTN_DOWN=4.
- One sub-module, time_of_day_counter: hh:mm:ss counter with enable, tick and synchronous load (seconds cleared on load).

Test Plan:
- Reset then 3661 ticks in CLOCK -> time 01:01:01; at 23:59:59 one more tick -> 00:00:00.
- Centre pulse -> adj_load high exactly 1 cycle, adj_enable=1; 10 ticks in ADJUST -> seconds unchanged; centre with adjusted=01, adj_time=07:30 -> time 07:30:00, alarm unchanged, alarm_armed=0.
- Commit alarm 07:31 (adjusted=10), time at 07:30:58; tick -> 07:30:59, buzzer=0; tick -> 07:31:00, buzzer=1 the next cycle, mode_led=10.
- RINGING with no buttons: buzzer drops after 60 ticks, state CLOCK, alarm_armed=1; re-ring with a left-button pulse at tick 5 -> buzzer=0 the next cycle.
- SNOOZE_EN defined with SNOOZE_MINUTES=1: up pulse while ringing -> mode_led=11, buzzer=0; after 60 ticks -> buzzer=1. Same stimulus without the macro -> dismiss to CLOCK.
- Reset asserted mid-RINGING, asynchronously between clock edges -> buzzer=0 immediately, time 00:00:00, alarm_armed=0.
